pc_hazard_controller: RTL and testbench

Sequencing controller for the program counter and pipeline registers of the 5-stage pipeline, where branches and jumps resolve in the Memory stage. It drives PCWrite and the next-PC value into the program counter, and the write/flush enables of IF/ID, ID/EX and EX/MEM. It covers post-reset hold, load-use stalls, taken-branch redirects with flushes, and a halt/drain sequence.

---
 rtl/pc_hazard_controller_pkg.sv | 23 ++
 rtl/pc_hazard_controller_if.sv | 51 +++++
 rtl/pc_hazard_controller_load_use_detect.sv | 24 ++
 rtl/pc_hazard_controller.sv | 170 +++++++++++++++++
 tb/tb_pc_hazard_controller.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_hazard_controller_pkg.sv
// Shared types and constants for pc_hazard_controller and its load-use detector.
// The statistics counters are built only when HAZARD_STATS_EN is defined.
package pc_hazard_controller_pkg;

  typedef enum logic [1:0] {
    StHold   = 2'd0,
    StRun    = 2'd1,
    StDrain  = 2'd2,
    StHalted = 2'd3
  } state_e;

  localparam int unsigned DrainLen = 2;
  localparam logic [4:0]  RegZero  = 5'd0;

  // One counter serves both the post-reset hold and the drain sequence.
  localparam int unsigned CntW = 4;
  typedef logic [CntW-1:0] cnt_t;

  function automatic cnt_t cnt_init(input int unsigned len);
    return cnt_t'(len - 1);
  endfunction

endpackage

// File: rtl/pc_hazard_controller_if.sv
// Pipeline-side signal bundle of pc_hazard_controller.
// COUNT_W, StallCount and FlushCount exist only when HAZARD_STATS_EN is defined.
interface pc_hazard_controller_if
`ifdef HAZARD_STATS_EN
  #(parameter int unsigned COUNT_W = 32)
`endif
  ;

  logic [4:0]  ID_Rs;
  logic [4:0]  ID_Rt;
  logic        ID_UsesRs;
  logic        ID_UsesRt;
  logic        ID_Halt;
  logic        EX_MemRead;
  logic [4:0]  EX_Rt;
  logic        MEM_BranchTaken;
  logic [31:0] MEM_Target;
  logic [31:0] IF_PCPlus4;

  logic        PCWrite;
  logic [31:0] PCNext;
  logic        IFIDWrite;
  logic        IFIDFlush;
  logic        IDEXFlush;
  logic        EXMEMFlush;
  logic        Halted;
  logic [1:0]  State;
`ifdef HAZARD_STATS_EN
  logic [COUNT_W-1:0] StallCount;
  logic [COUNT_W-1:0] FlushCount;
`endif

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_Halt, EX_MemRead, EX_Rt,
           MEM_BranchTaken, MEM_Target, IF_PCPlus4,
    input  PCWrite, PCNext, IFIDWrite, IFIDFlush, IDEXFlush, EXMEMFlush, Halted, State
`ifdef HAZARD_STATS_EN
           , StallCount, FlushCount
`endif
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_Halt, EX_MemRead, EX_Rt,
           MEM_BranchTaken, MEM_Target, IF_PCPlus4,
    output PCWrite, PCNext, IFIDWrite, IFIDFlush, IDEXFlush, EXMEMFlush, Halted, State
`ifdef HAZARD_STATS_EN
           , StallCount, FlushCount
`endif
  );

endinterface

// File: rtl/pc_hazard_controller_load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the reads in ID.
// Shared with the forwarding unit's bench, so it carries no controller state.
module load_use_detect
  import pc_hazard_controller_pkg::*;
(
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rt_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rs_i,
  input  logic       id_uses_rt_i,
  output logic       hazard_o
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_uses_rs_i && (id_rs_i == ex_rt_i);
  assign rt_hit = id_uses_rt_i && (id_rt_i == ex_rt_i);

  // A load into r0 never produces a value worth waiting for.
  assign hazard_o = ex_mem_read_i && (ex_rt_i != RegZero) && (rs_hit || rt_hit);

endmodule

// File: rtl/pc_hazard_controller.sv
// PC / pipeline-register sequencing: post-reset hold, load-use stall, MEM redirect, halt/drain.
// Define HAZARD_STATS_EN to add the saturating StallCount/FlushCount statistics.
module pc_hazard_controller
  import pc_hazard_controller_pkg::*;
#(
  parameter int unsigned RESET_HOLD_CYCLES = 2
`ifdef HAZARD_STATS_EN
  , parameter int unsigned COUNT_W = 32
`endif
) (
  input logic                   Clk,
  input logic                   Reset,
  pc_hazard_controller_if.slave bus
);

  localparam cnt_t HoldInit  = cnt_init(RESET_HOLD_CYCLES);
  localparam cnt_t DrainInit = cnt_init(DrainLen);

  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d;

  logic        load_use;
  logic        stall;
  logic        redirect;
  logic        pc_write;
  logic [31:0] pc_next;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        halted;

  load_use_detect u_load_use_detect (
    .ex_mem_read_i(bus.EX_MemRead),
    .ex_rt_i      (bus.EX_Rt),
    .id_rs_i      (bus.ID_Rs),
    .id_rt_i      (bus.ID_Rt),
    .id_uses_rs_i (bus.ID_UsesRs),
    .id_uses_rt_i (bus.ID_UsesRt),
    .hazard_o     (load_use)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall       = 1'b0;
    redirect    = 1'b0;
    pc_write    = 1'b0;
    pc_next     = bus.IF_PCPlus4;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    halted      = 1'b0;

    unique case (state_q)
      StHold: begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        if (cnt_q == '0) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRun: begin
        if (bus.MEM_BranchTaken) begin
          redirect = 1'b1;
        end else if (load_use) begin
          stall = 1'b1;
        end else if (bus.ID_Halt) begin
          ifid_flush = 1'b1;
          state_d    = StDrain;
          cnt_d      = DrainInit;
        end else begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
        end
      end
      StDrain: begin
        // A branch resolving in the first drain cycle is older than the halt,
        // so the halt was fetched down the wrong path.
        if (bus.MEM_BranchTaken && (cnt_q == DrainInit)) begin
          redirect = 1'b1;
          state_d  = StRun;
        end else begin
          ifid_flush = 1'b1;
          if (cnt_q == '0) begin
            state_d = StHalted;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      StHalted: begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        halted      = 1'b1;
      end
      default: begin
        state_d = StHold;
        cnt_d   = HoldInit;
      end
    endcase

    if (stall) begin
      idex_flush = 1'b1;
    end

    if (redirect) begin
      pc_write    = 1'b1;
      pc_next     = bus.MEM_Target;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StHold;
      cnt_q   <= HoldInit;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.PCWrite    = pc_write;
  assign bus.PCNext     = pc_next;
  assign bus.IFIDWrite  = ifid_write;
  assign bus.IFIDFlush  = ifid_flush;
  assign bus.IDEXFlush  = idex_flush;
  assign bus.EXMEMFlush = exmem_flush;
  assign bus.Halted     = halted;
  assign bus.State      = state_q;

`ifdef HAZARD_STATS_EN
  logic [COUNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [COUNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (redirect && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.StallCount = stall_cnt_q;
  assign bus.FlushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pc_hazard_controller.sv
// Self-checking bench for pc_hazard_controller: directed plan steps plus a random phase,
// compared every cycle against an action-level reference model (HAZARD_STATS_EN aware).
module tb_pc_hazard_controller;

  localparam int unsigned HoldCycles = 2;
  localparam int unsigned DrainCycles = 2;

  typedef enum int {ActHold, ActRedirect, ActStall, ActHaltEnter, ActAdvance, ActDrain,
                    ActHalted} act_e;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cyc;

  // Reference model state: 0=HOLD 1=RUN 2=DRAIN 3=HALTED
  int   m_mode;
  int   m_hold_seen;
  int   m_drain_idx;
  int   m_stalls;
  int   m_flushes;
  act_e m_act;

`ifdef HAZARD_STATS_EN
  pc_hazard_controller_if #(.COUNT_W(32)) bus ();
`else
  pc_hazard_controller_if bus ();
`endif

  pc_hazard_controller #(
    .RESET_HOLD_CYCLES(HoldCycles)
`ifdef HAZARD_STATS_EN
    , .COUNT_W(32)
`endif
  ) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic act_e decide();
    logic hz;
    hz = bus.EX_MemRead && (bus.EX_Rt != 5'd0) &&
         ((bus.ID_UsesRs && bus.ID_Rs == bus.EX_Rt) || (bus.ID_UsesRt && bus.ID_Rt == bus.EX_Rt));
    case (m_mode)
      0: return ActHold;
      1: begin
        if (bus.MEM_BranchTaken) return ActRedirect;
        if (hz) return ActStall;
        if (bus.ID_Halt) return ActHaltEnter;
        return ActAdvance;
      end
      2: return (m_drain_idx == 1 && bus.MEM_BranchTaken) ? ActRedirect : ActDrain;
      default: return ActHalted;
    endcase
  endfunction

  // {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, EXMEMFlush, Halted}
  function automatic logic [5:0] act_vec(input act_e a);
    case (a)
      ActHold:      return 6'b00_111_0;
      ActRedirect:  return 6'b11_111_0;
      ActStall:     return 6'b00_010_0;
      ActHaltEnter: return 6'b00_100_0;
      ActAdvance:   return 6'b11_000_0;
      ActDrain:     return 6'b00_100_0;
      default:      return 6'b00_111_1;
    endcase
  endfunction

  task automatic settle();
    logic [5:0] v;
    #1;
    m_act = decide();
    v = act_vec(m_act);
    chk("PCWrite", 32'(bus.PCWrite), 32'(v[5]));
    chk("IFIDWrite", 32'(bus.IFIDWrite), 32'(v[4]));
    chk("IFIDFlush", 32'(bus.IFIDFlush), 32'(v[3]));
    chk("IDEXFlush", 32'(bus.IDEXFlush), 32'(v[2]));
    chk("EXMEMFlush", 32'(bus.EXMEMFlush), 32'(v[1]));
    chk("Halted", 32'(bus.Halted), 32'(v[0]));
    chk("PCNext", bus.PCNext, (m_act == ActRedirect) ? bus.MEM_Target : bus.IF_PCPlus4);
    chk("State", 32'(bus.State), 32'(m_mode));
`ifdef HAZARD_STATS_EN
    chk("StallCount", bus.StallCount, 32'(m_stalls));
    chk("FlushCount", bus.FlushCount, 32'(m_flushes));
`endif
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_hold_seen = 0;
    m_drain_idx = 0;
    m_stalls = 0;
    m_flushes = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      case (m_act)
        ActHold: begin
          m_hold_seen++;
          if (m_hold_seen >= int'(HoldCycles)) m_mode = 1;
        end
        ActRedirect: begin
          m_flushes++;
          m_mode = 1;
        end
        ActStall: m_stalls++;
        ActHaltEnter: begin
          m_mode = 2;
          m_drain_idx = 1;
        end
        ActDrain: begin
          if (m_drain_idx >= int'(DrainCycles)) m_mode = 3;
          else m_drain_idx++;
        end
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic idle();
    bus.ID_Rs = 5'd0;
    bus.ID_Rt = 5'd0;
    bus.ID_UsesRs = 1'b0;
    bus.ID_UsesRt = 1'b0;
    bus.ID_Halt = 1'b0;
    bus.EX_MemRead = 1'b0;
    bus.EX_Rt = 5'd0;
    bus.MEM_BranchTaken = 1'b0;
    bus.MEM_Target = 32'h0;
  endtask

  task automatic load_use(input logic [4:0] r);
    bus.EX_MemRead = 1'b1;
    bus.EX_Rt = r;
    bus.ID_Rs = r;
    bus.ID_UsesRs = 1'b1;
  endtask

  task automatic reset_to_run();
    idle();
    rst = 1'b1;
    settle();
    tick();
    rst = 1'b0;
    repeat (HoldCycles) begin
      settle();
      tick();
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    rst = 1'b1;
    idle();
    bus.IF_PCPlus4 = 32'h4;
    model_reset();
    @(posedge clk);
    #1;

    // Reset held, then released: two hold cycles, then the first increment.
    repeat (3) begin
      settle();
      tick();
    end
    rst = 1'b0;
    settle();
    chk("plan_hold1_pcwrite", 32'(bus.PCWrite), 32'd0);
    tick();
    settle();
    chk("plan_hold2_pcwrite", 32'(bus.PCWrite), 32'd0);
    tick();
    settle();
    chk("plan_run_pcwrite", 32'(bus.PCWrite), 32'd1);
    chk("plan_run_pcnext", bus.PCNext, 32'h4);
    tick();

    // Load-use stall, then the same pattern against r0.
    load_use(5'd5);
    settle();
    chk("plan_stall_pcwrite", 32'(bus.PCWrite), 32'd0);
    chk("plan_stall_idex", 32'(bus.IDEXFlush), 32'd1);
    tick();
    idle();
    settle();
    chk("plan_after_stall", 32'(bus.PCWrite), 32'd1);
    tick();
    load_use(5'd0);
    settle();
    chk("plan_r0_nostall", 32'(bus.PCWrite), 32'd1);
    tick();

    // Redirect coincident with a hazard wins.
    load_use(5'd5);
    bus.MEM_BranchTaken = 1'b1;
    bus.MEM_Target = 32'h40;
    settle();
    chk("plan_br_pcnext", bus.PCNext, 32'h40);
    chk("plan_br_exmem", 32'(bus.EXMEMFlush), 32'd1);
    tick();

    // Halt and drain to HALTED.
    idle();
    bus.ID_Halt = 1'b1;
    settle();
    chk("plan_halt_state_run", 32'(bus.State), 32'd1);
    tick();
    idle();
    settle();
    chk("plan_drain1", 32'(bus.State), 32'd2);
    tick();
    settle();
    chk("plan_drain2", 32'(bus.State), 32'd2);
    tick();
    settle();
    chk("plan_halted_state", 32'(bus.State), 32'd3);
    chk("plan_halted_flag", 32'(bus.Halted), 32'd1);
    tick();
    repeat (3) begin
      settle();
      chk("plan_halted_pcwrite", 32'(bus.PCWrite), 32'd0);
      tick();
    end

    // Wrong-path halt cancelled by a branch in the first drain cycle.
    reset_to_run();
    bus.ID_Halt = 1'b1;
    settle();
    tick();
    idle();
    bus.MEM_BranchTaken = 1'b1;
    bus.MEM_Target = 32'h80;
    settle();
    chk("plan_cancel_pcnext", bus.PCNext, 32'h80);
    chk("plan_cancel_pcwrite", 32'(bus.PCWrite), 32'd1);
    tick();
    idle();
    settle();
    chk("plan_cancel_state", 32'(bus.State), 32'd1);
    chk("plan_cancel_halted", 32'(bus.Halted), 32'd0);
    tick();

`ifdef HAZARD_STATS_EN
    reset_to_run();
    for (int i = 0; i < 3; i++) begin
      load_use(5'(i + 1));
      settle();
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      idle();
      bus.MEM_BranchTaken = 1'b1;
      bus.MEM_Target = 32'h100 + 32'(i);
      settle();
      tick();
    end
    idle();
    settle();
    chk("plan_stallcount", bus.StallCount, 32'd3);
    chk("plan_flushcount", bus.FlushCount, 32'd2);
    rst = 1'b1;
    tick();
    settle();
    chk("plan_stallcount_rst", bus.StallCount, 32'd0);
    chk("plan_flushcount_rst", bus.FlushCount, 32'd0);
    tick();
    rst = 1'b0;
`endif

    // Random phase against the model.
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      bus.ID_Rs = 5'($urandom_range(0, 3));
      bus.ID_Rt = 5'($urandom_range(0, 3));
      bus.ID_UsesRs = 1'($urandom_range(0, 1));
      bus.ID_UsesRt = 1'($urandom_range(0, 1));
      bus.ID_Halt = ($urandom_range(0, 15) == 0);
      bus.EX_MemRead = 1'($urandom_range(0, 1));
      bus.EX_Rt = 5'($urandom_range(0, 3));
      bus.MEM_BranchTaken = ($urandom_range(0, 7) == 0);
      bus.MEM_Target = $urandom;
      bus.IF_PCPlus4 = $urandom;
      settle();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
